linear_proj_ctrl: RTL and testbench

Tile scheduler for the linear-projection datapath. It walks the output matrix C tile by tile in row-major order. For each tile it streams the K block-addresses of the A (input) and B (weight) memories into the multi-matmul array, waits for the array's completion pulse, then presents the finished tile index to the downstream writer over a valid/ready handshake. One instance sits per projection (Q/K/V) between the A/B memories and multi_matmul_wrapper.

---
 rtl/linear_proj_ctrl.sv | 238 +++++++++++++++++++++++
 tb/tb_linear_proj_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/linear_proj_ctrl.sv
// linear_proj_ctrl: tile scheduler for one linear projection (Q/K/V).
// Walks the C tiles in row-major order. For each tile it streams K block
// addresses to the A/B memories, waits for the matmul completion pulse, then
// hands the tile index to the writer over a valid/ready handshake.

package linear_proj_pkg;
  localparam int unsigned ROW_SIZE_MAT_C  = 2;
  localparam int unsigned COL_SIZE_MAT_C  = 2;
  localparam int unsigned INNER_DIMENSION = 12;
  localparam int unsigned BLOCK_SIZE      = 4;
  localparam int unsigned ADDR_WIDTH_A    = 8;
  localparam int unsigned ADDR_WIDTH_B    = 8;
  localparam int unsigned MAX_FLAG        = ROW_SIZE_MAT_C * COL_SIZE_MAT_C;
endpackage

module linear_proj_ctrl #(
  parameter int unsigned ROW_TILES    = linear_proj_pkg::ROW_SIZE_MAT_C,
  parameter int unsigned COL_TILES    = linear_proj_pkg::COL_SIZE_MAT_C,
  parameter int unsigned K_STEPS      = linear_proj_pkg::INNER_DIMENSION / linear_proj_pkg::BLOCK_SIZE,
  parameter int unsigned ADDR_WIDTH_A = linear_proj_pkg::ADDR_WIDTH_A,
  parameter int unsigned ADDR_WIDTH_B = linear_proj_pkg::ADDR_WIDTH_B,
  parameter int unsigned FLAG_WIDTH   = $clog2(linear_proj_pkg::MAX_FLAG) + 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        abort,
  output logic                        a_en,
  output logic [ADDR_WIDTH_A-1:0]     a_addr,
  output logic                        b_en,
  output logic [ADDR_WIDTH_B-1:0]     b_addr,
  output logic                        mm_in_valid,
  output logic                        mm_in_last,
  input  logic                        mm_done,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [$clog2(ROW_TILES):0]  out_row,
  output logic [$clog2(COL_TILES):0]  out_col,
  output logic [FLAG_WIDTH-1:0]       flag,
  output logic                        busy,
  output logic                        done
);

  localparam int unsigned RW = $clog2(ROW_TILES) + 1;
  localparam int unsigned CW = $clog2(COL_TILES) + 1;
  localparam int unsigned KW = $clog2(K_STEPS) + 1;

  localparam logic [RW-1:0] R_LAST = RW'(ROW_TILES - 1);
  localparam logic [CW-1:0] C_LAST = CW'(COL_TILES - 1);
  localparam logic [KW-1:0] K_LAST = KW'(K_STEPS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FEED,
    S_WAIT,
    S_OUT,
    S_FIN
  } state_e;

  state_e                  state_q, state_d;
  logic [RW-1:0]           r_q, r_d;
  logic [CW-1:0]           c_q, c_d;
  logic [KW-1:0]           k_q, k_d;
  logic                    done_seen_q, done_seen_d;

  logic                    a_en_q, a_en_d;
  logic [ADDR_WIDTH_A-1:0] a_addr_q, a_addr_d;
  logic                    b_en_q, b_en_d;
  logic [ADDR_WIDTH_B-1:0] b_addr_q, b_addr_d;
  logic                    mm_in_valid_q, mm_in_valid_d;
  logic                    mm_in_last_q, mm_in_last_d;
  logic                    out_valid_q, out_valid_d;
  logic [RW-1:0]           out_row_q, out_row_d;
  logic [CW-1:0]           out_col_q, out_col_d;
  logic [FLAG_WIDTH-1:0]   flag_q, flag_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic                    abort_hit;
  logic                    feed_d;
  logic                    out_d;

  // State, counters and every output are held in flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      r_q           <= '0;
      c_q           <= '0;
      k_q           <= '0;
      done_seen_q   <= 1'b0;
      a_en_q        <= 1'b0;
      a_addr_q      <= '0;
      b_en_q        <= 1'b0;
      b_addr_q      <= '0;
      mm_in_valid_q <= 1'b0;
      mm_in_last_q  <= 1'b0;
      out_valid_q   <= 1'b0;
      out_row_q     <= '0;
      out_col_q     <= '0;
      flag_q        <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      r_q           <= r_d;
      c_q           <= c_d;
      k_q           <= k_d;
      done_seen_q   <= done_seen_d;
      a_en_q        <= a_en_d;
      a_addr_q      <= a_addr_d;
      b_en_q        <= b_en_d;
      b_addr_q      <= b_addr_d;
      mm_in_valid_q <= mm_in_valid_d;
      mm_in_last_q  <= mm_in_last_d;
      out_valid_q   <= out_valid_d;
      out_row_q     <= out_row_d;
      out_col_q     <= out_col_d;
      flag_q        <= flag_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  // Next state and tile/k counters; abort overrides every transition.
  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    c_d         = c_q;
    k_d         = k_q;
    done_seen_d = done_seen_q;
    abort_hit   = abort && (state_q != S_IDLE);

    if (abort_hit) begin
      state_d     = S_IDLE;
      r_d         = '0;
      c_d         = '0;
      k_d         = '0;
      done_seen_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            state_d     = S_FEED;
            r_d         = '0;
            c_d         = '0;
            k_d         = '0;
            done_seen_d = 1'b0;
          end
        end
        S_FEED: begin
          if (mm_done) begin
            done_seen_d = 1'b1;
          end
          if (k_q == K_LAST) begin
            k_d     = '0;
            state_d = S_WAIT;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
        S_WAIT: begin
          if (mm_done || done_seen_q) begin
            state_d     = S_OUT;
            done_seen_d = 1'b0;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            if ((r_q == R_LAST) && (c_q == C_LAST)) begin
              state_d = S_FIN;
            end else begin
              if (c_q == C_LAST) begin
                c_d = '0;
                r_d = r_q + 1'b1;
              end else begin
                c_d = c_q + 1'b1;
              end
              state_d = S_FEED;
            end
          end
        end
        S_FIN: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they come straight from flops.
  // The matmul operand strobes lag the memory enables by one cycle to line up
  // with the BRAM read latency; an abort drops them along with everything else.
  always_comb begin
    feed_d        = (state_d == S_FEED);
    out_d         = (state_d == S_OUT);

    a_en_d        = feed_d;
    b_en_d        = feed_d;
    a_addr_d      = '0;
    b_addr_d      = '0;
    if (feed_d) begin
      a_addr_d = ADDR_WIDTH_A'(32'(r_d) * K_STEPS + 32'(k_d));
      b_addr_d = ADDR_WIDTH_B'(32'(c_d) * K_STEPS + 32'(k_d));
    end

    mm_in_valid_d = a_en_q && !abort_hit;
    mm_in_last_d  = (state_q == S_FEED) && (k_q == K_LAST) && !abort_hit;

    out_valid_d   = out_d;
    out_row_d     = '0;
    out_col_d     = '0;
    flag_d        = '0;
    if (out_d) begin
      out_row_d = r_d;
      out_col_d = c_d;
      flag_d    = FLAG_WIDTH'(32'(r_d) * COL_TILES + 32'(c_d));
    end

    busy_d        = (state_d != S_IDLE);
    done_d        = (state_d == S_FIN);
  end

  assign a_en        = a_en_q;
  assign a_addr      = a_addr_q;
  assign b_en        = b_en_q;
  assign b_addr      = b_addr_q;
  assign mm_in_valid = mm_in_valid_q;
  assign mm_in_last  = mm_in_last_q;
  assign out_valid   = out_valid_q;
  assign out_row     = out_row_q;
  assign out_col     = out_col_q;
  assign flag        = flag_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_linear_proj_ctrl.sv
// Directed bench for linear_proj_ctrl with a 2x2 tile grid and K_STEPS=3.
module tb_linear_proj_ctrl;

  localparam int unsigned RT  = 2;
  localparam int unsigned CT  = 2;
  localparam int unsigned KS  = 3;
  localparam int unsigned AW  = 8;
  localparam int unsigned BW  = 8;
  localparam int unsigned FW  = 3;
  localparam int unsigned RWB = $clog2(RT) + 1;
  localparam int unsigned CWB = $clog2(CT) + 1;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           start = 1'b0;
  logic           abort = 1'b0;
  logic           out_ready = 1'b0;
  logic           man_done = 1'b0;
  logic           auto_done = 1'b0;
  logic           mm_done;
  logic           a_en, b_en, mm_in_valid, mm_in_last, out_valid, busy, done;
  logic [AW-1:0]  a_addr;
  logic [BW-1:0]  b_addr;
  logic [RWB-1:0] out_row;
  logic [CWB-1:0] out_col;
  logic [FW-1:0]  flag;

  assign mm_done = man_done | auto_done;

  always #5 clk = ~clk;

  linear_proj_ctrl #(
    .ROW_TILES(RT),
    .COL_TILES(CT),
    .K_STEPS(KS),
    .ADDR_WIDTH_A(AW),
    .ADDR_WIDTH_B(BW),
    .FLAG_WIDTH(FW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .abort(abort),
    .a_en(a_en),
    .a_addr(a_addr),
    .b_en(b_en),
    .b_addr(b_addr),
    .mm_in_valid(mm_in_valid),
    .mm_in_last(mm_in_last),
    .mm_done(mm_done),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_row(out_row),
    .out_col(out_col),
    .flag(flag),
    .busy(busy),
    .done(done)
  );

  // Hand-computed expectations for a complete 2x2, K=3 projection.
  int unsigned EXP_A[12] = '{0, 1, 2, 0, 1, 2, 3, 4, 5, 3, 4, 5};
  int unsigned EXP_B[12] = '{0, 1, 2, 3, 4, 5, 0, 1, 2, 3, 4, 5};
  int unsigned EXP_F[4]  = '{0, 1, 2, 3};
  int unsigned EXP_R[4]  = '{0, 0, 1, 1};
  int unsigned EXP_C[4]  = '{0, 1, 0, 1};

  int n_cmp = 0;
  int n_err = 0;

  bit          auto_en = 1'b0;
  int unsigned aq[$], bq[$], fq[$], rq[$], cq[$];
  int          done_cnt, last_cnt, lag_err, last_err, done_busy_err;
  bit          prev_a_en = 1'b0;
  bit          prev_done = 1'b0;
  logic        busy_after_done;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Matmul stand-in: raises mm_done two cycles after each mm_in_last.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      auto_done = 1'b0;
      if (!auto_en) begin
        cnt = 0;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) auto_done = 1'b1;
        end
        if (mm_in_last) cnt = 2;
      end
    end
  end

  // Monitor: records addresses, accepted tiles, done pulses, strobe alignment.
  always @(negedge clk) begin
    #2;
    if (a_en) begin
      aq.push_back(32'(a_addr));
      bq.push_back(32'(b_addr));
    end
    if (out_valid && out_ready) begin
      fq.push_back(32'(flag));
      rq.push_back(32'(out_row));
      cq.push_back(32'(out_col));
    end
    if (done) done_cnt++;
    if (done && !busy) done_busy_err++;
    if (prev_done) busy_after_done = busy;
    if (mm_in_valid != prev_a_en) lag_err++;
    if (mm_in_last) begin
      last_cnt++;
      if (!(prev_a_en && !a_en && mm_in_valid)) last_err++;
    end
    prev_a_en = a_en;
    prev_done = done;
  end

  task automatic clear_mon();
    aq.delete(); bq.delete(); fq.delete(); rq.delete(); cq.delete();
    done_cnt = 0; last_cnt = 0; lag_err = 0; last_err = 0; done_busy_err = 0;
    busy_after_done = 1'b1;
  endtask

  task automatic check_zero_outs(input string tag);
    check_eq(tag, 64'({a_en, a_addr, b_en, b_addr, mm_in_valid, mm_in_last,
                       out_valid, out_row, out_col, flag, busy, done}), 64'd0);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input int maxc, input string tag);
    int n;
    n = 0;
    while (!done && n < maxc) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 64'(done), 64'd1);
  endtask

  task automatic wait_valid_flag(input int unsigned fv, input int maxc, input string tag);
    int n;
    n = 0;
    while (!(out_valid && (32'(flag) == fv)) && n < maxc) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 64'({out_valid, flag}), 64'({1'b1, fv[FW-1:0]}));
  endtask

  task automatic check_run(input string tag);
    check_eq({tag, "_na"}, 64'(aq.size()), 64'd12);
    for (int i = 0; i < 12; i++) begin
      if (i < aq.size()) begin
        check_eq($sformatf("%s_a%0d", tag, i), 64'(aq[i]), 64'(EXP_A[i]));
        check_eq($sformatf("%s_b%0d", tag, i), 64'(bq[i]), 64'(EXP_B[i]));
      end
    end
    check_eq({tag, "_ntiles"}, 64'(fq.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < fq.size()) begin
        check_eq($sformatf("%s_flag%0d", tag, i), 64'(fq[i]), 64'(EXP_F[i]));
        check_eq($sformatf("%s_row%0d", tag, i), 64'(rq[i]), 64'(EXP_R[i]));
        check_eq($sformatf("%s_col%0d", tag, i), 64'(cq[i]), 64'(EXP_C[i]));
      end
    end
    check_eq({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
    check_eq({tag, "_busy_with_done"}, 64'(done_busy_err), 64'd0);
    check_eq({tag, "_busy_after_done"}, 64'(busy_after_done), 64'd0);
    check_eq({tag, "_valid_lag"}, 64'(lag_err), 64'd0);
    check_eq({tag, "_last_cnt"}, 64'(last_cnt), 64'd4);
    check_eq({tag, "_last_pos"}, 64'(last_err), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1);
  end

  initial begin
    clear_mon();
    out_ready = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_zero_outs("reset");
    rst_n = 1'b1;

    // start together with abort in IDLE: stays idle
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    check_eq("abort_start_idle", 64'({busy, a_en}), 64'd0);

    // Full run, ready tied high, mm_done two cycles after mm_in_last
    clear_mon();
    auto_en = 1'b1;
    pulse_start();
    wait_done(200, "full_done");
    repeat (3) @(negedge clk);
    check_run("full");

    // Asynchronous reset during the second FEED cycle
    auto_en = 1'b0;
    pulse_start();
    check_eq("rst_feed1", 64'({a_en, a_addr}), 64'({1'b1, 8'd0}));
    @(negedge clk);
    check_eq("rst_feed2", 64'({a_en, a_addr}), 64'({1'b1, 8'd1}));
    #1 rst_n = 1'b0;
    #1 check_zero_outs("rst_async");
    @(negedge clk); rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("rst_stays_idle", 64'({busy, a_en}), 64'd0);

    // Backpressure on tile 1
    clear_mon();
    auto_en = 1'b1;
    out_ready = 1'b1;
    pulse_start();
    wait_valid_flag(1, 100, "bp_reach");
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_eq($sformatf("bp_hold%0d", i), 64'({out_valid, flag, out_row, out_col, a_en}),
               64'({1'b1, 3'd1, 2'd0, 2'd1, 1'b0}));
      @(negedge clk);
    end
    out_ready = 1'b1;
    wait_done(200, "bp_done");
    repeat (3) @(negedge clk);
    check_run("bp");

    // Early mm_done, stray mm_done in OUT, then abort in WAIT of tile 2
    auto_en = 1'b0;
    clear_mon();
    pulse_start();
    @(negedge clk);
    @(negedge clk);
    check_eq("early_lastfeed", 64'({a_en, a_addr}), 64'({1'b1, 8'd2}));
    man_done = 1'b1;
    @(negedge clk); man_done = 1'b0;
    check_eq("early_wait", 64'({a_en, out_valid, busy}), 64'b001);
    @(negedge clk);
    check_eq("early_out", 64'({out_valid, flag}), 64'({1'b1, 3'd0}));
    out_ready = 1'b0;
    man_done = 1'b1;
    @(negedge clk); man_done = 1'b0;
    check_eq("early_out_hold", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("t1_feed", 64'({a_en, a_addr, b_addr}), 64'({1'b1, 8'd0, 8'd3}));
    repeat (3) @(negedge clk);
    repeat (4) @(negedge clk);
    check_eq("stray_done_ignored", 64'({out_valid, busy}), 64'b01);
    man_done = 1'b1;
    @(negedge clk); man_done = 1'b0;
    check_eq("t1_out", 64'({out_valid, flag}), 64'({1'b1, 3'd1}));
    @(negedge clk);
    check_eq("t2_feed", 64'({a_en, a_addr, b_addr}), 64'({1'b1, 8'd3, 8'd0}));
    repeat (3) @(negedge clk);
    check_eq("t2_wait", 64'({a_en, out_valid, busy}), 64'b001);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check_zero_outs("abort_idle");
    repeat (5) @(negedge clk);
    check_eq("abort_no_done", 64'(done_cnt), 64'd0);

    // Restart after abort begins again at tile 0
    clear_mon();
    auto_en = 1'b1;
    pulse_start();
    check_eq("restart_feed", 64'({a_en, a_addr, b_addr}), 64'({1'b1, 8'd0, 8'd0}));
    wait_done(200, "restart_done");
    repeat (3) @(negedge clk);
    check_run("restart");

    // mm_done in IDLE and start while busy are ignored
    clear_mon();
    @(negedge clk); man_done = 1'b1;
    @(negedge clk); man_done = 1'b0;
    @(negedge clk);
    check_eq("idle_mm_done", 64'({busy, a_en}), 64'd0);
    pulse_start();
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (6) @(negedge clk);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done(200, "ign_done");
    repeat (3) @(negedge clk);
    check_run("ign");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
